// File: rtl/ex_mem_stage_pkg.sv
// ex_mem_pkg: shared types and helpers for the execute-to-memory pipeline stage.
// Contents:
//   EX_MEM_DATA_WIDTH / EX_MEM_REG_ADDR_WIDTH  default datapath widths
//   branch_op_t                                branch/jump opcode carried with each entry
//   ex_mem_payload_t                           fields registered into the memory stage
//   branch_taken()                             branch decision from the ALU flags
package ex_mem_pkg;

    localparam int EX_MEM_DATA_WIDTH     = 64;
    localparam int EX_MEM_REG_ADDR_WIDTH = 5;

    typedef enum logic [2:0] {
        NONE = 3'd0,
        BEQ  = 3'd1,
        BNE  = 3'd2,
        BLT  = 3'd3,
        BGE  = 3'd4,
        JAL  = 3'd5
    } branch_op_t;

    typedef struct packed {
        logic [EX_MEM_DATA_WIDTH-1:0]     result;
        logic [EX_MEM_DATA_WIDTH-1:0]     store_data;
        logic [EX_MEM_REG_ADDR_WIDTH-1:0] rd_addr;
        logic                             mem_read;
        logic                             mem_write;
        logic                             reg_write;
        logic                             overflow;
    } ex_mem_payload_t;

    // Codes 6 and 7 are not defined and fall into the default (never taken).
    function automatic logic branch_taken(input branch_op_t op, input logic equal, input logic less);
        case (op)
            BEQ:     return equal;
            BNE:     return !equal;
            BLT:     return less;
            BGE:     return !less;
            JAL:     return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if: upstream ALU bundle, downstream memory-stage bundle and fetch redirect.
// Ports (slave = the stage, master = its environment):
//   flush                              synchronous pipeline flush
//   in_valid / in_ready                upstream handshake
//   alu_result, alu_* flags            ALU outputs for the entry
//   store_data, rd_addr, pc, imm       operands carried with the entry
//   branch_op, mem_read/write, reg_write  instruction controls
//   out_valid / out_ready              downstream handshake
//   out_*                              registered entry for the memory stage
//   redirect_valid / redirect_target   one-cycle fetch redirect
interface ex_mem_stage_if
    import ex_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = EX_MEM_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = EX_MEM_REG_ADDR_WIDTH
);
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic                      alu_overflow;
    logic                      alu_negative;
    logic                      alu_zero;
    logic                      alu_equal;
    logic                      alu_greater;
    logic                      alu_less;
    logic [DATA_WIDTH-1:0]     store_data;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     imm;
    logic [2:0]                branch_op;
    logic                      mem_read;
    logic                      mem_write;
    logic                      reg_write;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WIDTH-1:0]     out_result;
    logic [DATA_WIDTH-1:0]     out_store_data;
    logic [REG_ADDR_WIDTH-1:0] out_rd_addr;
    logic                      out_mem_read;
    logic                      out_mem_write;
    logic                      out_reg_write;
    logic                      out_overflow;
    logic                      redirect_valid;
    logic [DATA_WIDTH-1:0]     redirect_target;

    modport slave (
        input  flush, in_valid, alu_result, alu_overflow, alu_negative, alu_zero,
               alu_equal, alu_greater, alu_less, store_data, rd_addr, pc, imm,
               branch_op, mem_read, mem_write, reg_write, out_ready,
        output in_ready, out_valid, out_result, out_store_data, out_rd_addr,
               out_mem_read, out_mem_write, out_reg_write, out_overflow,
               redirect_valid, redirect_target
    );

    modport master (
        output flush, in_valid, alu_result, alu_overflow, alu_negative, alu_zero,
               alu_equal, alu_greater, alu_less, store_data, rd_addr, pc, imm,
               branch_op, mem_read, mem_write, reg_write, out_ready,
        input  in_ready, out_valid, out_result, out_store_data, out_rd_addr,
               out_mem_read, out_mem_write, out_reg_write, out_overflow,
               redirect_valid, redirect_target
    );

endinterface

// File: rtl/ex_mem_stage_skid_buffer.sv
// skid_buffer: two-register valid/ready FIFO (main + skid) for an arbitrary payload type.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   flush                 synchronous clear of both registers
//   in_valid / in_ready   upstream handshake; in_ready is the registered !skid_valid
//   in_data               payload to store
//   out_valid / out_ready downstream handshake driven from the main register
//   out_data              main register contents
module skid_buffer #(
    parameter type T = logic [7:0]
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic skid_valid;
    T     skid_data;
    logic push;
    logic load;

    assign in_ready = ~skid_valid;
    assign push     = in_valid & in_ready;
    // Main can take a new entry when it is empty or emptying this cycle.
    assign load     = ~out_valid | out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (load) begin
            // A full skid blocks push, so the skid entry always goes first.
            out_valid  <= skid_valid | push;
            skid_valid <= 1'b0;
            if (skid_valid | push)
                out_data <= skid_valid ? skid_data : in_data;
        end else if (push) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: registers ALU results into a 2-entry skid buffer and resolves branches.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    ex_mem_stage_if.slave: upstream ALU handshake, downstream memory-stage
//          handshake, flush, and the one-cycle redirect_valid/redirect_target pulse
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = EX_MEM_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = EX_MEM_REG_ADDR_WIDTH
) (
    input logic          clk,
    input logic          reset,
    ex_mem_stage_if.slave bus
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     result;
        logic [DATA_WIDTH-1:0]     store_data;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        logic                      mem_read;
        logic                      mem_write;
        logic                      reg_write;
        logic                      overflow;
    } payload_t;

    payload_t              in_payload;
    payload_t              out_payload;
    logic                  buf_in_ready;
    logic                  buf_out_valid;
    logic                  accept;
    logic                  keep;
    logic                  taken;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_target;
    logic                  unused_flags;

    assign unused_flags = bus.alu_negative ^ bus.alu_zero ^ bus.alu_greater;

    assign in_payload = '{
        result:     bus.alu_result,
        store_data: bus.store_data,
        rd_addr:    bus.rd_addr,
        mem_read:   bus.mem_read,
        mem_write:  bus.mem_write,
        reg_write:  bus.reg_write,
        overflow:   bus.alu_overflow
    };

    // The handshake completes for squashed entries too; they are just not stored.
    assign accept = bus.in_valid & buf_in_ready;
    assign keep   = bus.in_valid & ~redirect_valid;
    assign taken  = accept & ~redirect_valid & branch_taken(branch_op_t'(bus.branch_op), bus.alu_equal, bus.alu_less);

    skid_buffer #(.T(payload_t)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.flush),
        .in_valid  (keep),
        .in_ready  (buf_in_ready),
        .in_data   (in_payload),
        .out_valid (buf_out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_payload)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_valid  <= 1'b0;
            redirect_target <= '0;
        end else if (bus.flush) begin
            redirect_valid  <= 1'b0;
        end else begin
            redirect_valid  <= taken;
            if (taken)
                redirect_target <= bus.pc + bus.imm;
        end
    end

    assign bus.in_ready        = buf_in_ready;
    assign bus.out_valid       = buf_out_valid;
    assign bus.out_result      = out_payload.result;
    assign bus.out_store_data  = out_payload.store_data;
    assign bus.out_rd_addr     = out_payload.rd_addr;
    assign bus.out_mem_read    = out_payload.mem_read;
    assign bus.out_mem_write   = out_payload.mem_write;
    assign bus.out_reg_write   = out_payload.reg_write;
    assign bus.out_overflow    = out_payload.overflow;
    assign bus.redirect_valid  = redirect_valid;
    assign bus.redirect_target = redirect_target;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed stimulus, a FIFO-level reference model and literal spot checks.
module tb_ex_mem_stage;
    import ex_mem_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ex_mem_stage_if #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5)) bus ();

    ex_mem_stage #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ex_mem_payload_t q[$];
    logic            m_rv  = 1'b0;
    logic [63:0]     m_tgt = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic spec_taken(input logic [2:0] op, input logic eq, input logic lt);
        return (op == 3'd1 && eq) || (op == 3'd2 && !eq) || (op == 3'd3 && lt) || (op == 3'd4 && !lt) || op == 3'd5;
    endfunction

    // Reference: a 2-deep FIFO; ready whenever fewer than two entries are held.
    initial begin
        logic acc, drain, tk;
        ex_mem_payload_t p;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                q.delete();
                m_rv = 1'b0;
            end else begin
                acc   = bus.in_valid && q.size() < 2;
                drain = q.size() > 0 && bus.out_ready;
                tk    = acc && !m_rv && spec_taken(bus.branch_op, bus.alu_equal, bus.alu_less);
                p     = '{bus.alu_result, bus.store_data, bus.rd_addr, bus.mem_read,
                          bus.mem_write, bus.reg_write, bus.alu_overflow};
                if (bus.flush) begin
                    q.delete();
                    m_rv = 1'b0;
                end else begin
                    if (drain) void'(q.pop_front());
                    if (acc && !m_rv) q.push_back(p);
                    if (tk) m_tgt = bus.pc + bus.imm;
                    m_rv = tk;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("model out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
            chk("model in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
            chk("model redirect_valid", 64'(bus.redirect_valid), 64'(m_rv));
            if (bus.out_valid && q.size() > 0) begin
                chk("model out_result", bus.out_result, q[0].result);
                chk("model out_store_data", bus.out_store_data, q[0].store_data);
                chk("model out_ctrl",
                    64'({bus.out_rd_addr, bus.out_mem_read, bus.out_mem_write, bus.out_reg_write, bus.out_overflow}),
                    64'({q[0].rd_addr, q[0].mem_read, q[0].mem_write, q[0].reg_write, q[0].overflow}));
            end
            if (bus.redirect_valid && m_rv)
                chk("model redirect_target", bus.redirect_target, m_tgt);
        end
    end

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.branch_op = 3'd0;
        bus.alu_equal = 1'b0;
        bus.alu_less  = 1'b0;
    endtask

    task automatic send(input logic [63:0] res, input logic [2:0] op, input logic eq, input logic lt,
                        input logic [63:0] pcv, input logic [63:0] immv);
        bus.in_valid     = 1'b1;
        bus.alu_result   = res;
        bus.store_data   = res ^ 64'hA5A5_0000_FFFF_1234;
        bus.rd_addr      = res[4:0];
        bus.mem_read     = res[0];
        bus.mem_write    = res[1];
        bus.reg_write    = 1'b1;
        bus.alu_overflow = res[2];
        bus.alu_negative = res[3];
        bus.alu_zero     = (res == 0);
        bus.alu_greater  = res[5];
        bus.branch_op    = op;
        bus.alu_equal    = eq;
        bus.alu_less     = lt;
        bus.pc           = pcv;
        bus.imm          = immv;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic [2:0] ops [8] = '{3'd3, 3'd4, 3'd3, 3'd4, 3'd6, 3'd7, 3'd1, 3'd2};
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        send(0, 0, 0, 0, 0, 0);
        idle();
        step();
        step();
        chk("reset out_valid", 64'(bus.out_valid), 0);
        chk("reset in_ready", 64'(bus.in_ready), 1);
        chk("reset redirect_valid", 64'(bus.redirect_valid), 0);
        chk("reset out_result", bus.out_result, 0);
        chk("reset redirect_target", bus.redirect_target, 0);
        reset = 1'b0;

        bus.out_ready = 1'b1;
        send(37, 0, 0, 0, 0, 0);
        bus.rd_addr = 5;
        step();
        idle();
        chk("single out_valid", 64'(bus.out_valid), 1);
        chk("single out_result", bus.out_result, 37);
        chk("single out_rd_addr", 64'(bus.out_rd_addr), 5);
        chk("single out_reg_write", 64'(bus.out_reg_write), 1);
        step();
        chk("single drop", 64'(bus.out_valid), 0);

        bus.out_ready = 1'b0;
        send(10, 0, 0, 0, 0, 0);
        step();
        send(20, 0, 0, 0, 0, 0);
        step();
        chk("bp in_ready low", 64'(bus.in_ready), 0);
        send(30, 0, 0, 0, 0, 0);
        step();
        chk("bp held in_ready", 64'(bus.in_ready), 0);
        chk("bp first", bus.out_result, 10);
        bus.out_ready = 1'b1;
        step();
        chk("bp second", bus.out_result, 20);
        chk("bp in_ready back", 64'(bus.in_ready), 1);
        step();
        idle();
        chk("bp third", bus.out_result, 30);
        chk("bp third valid", 64'(bus.out_valid), 1);
        step();
        chk("bp empty", 64'(bus.out_valid), 0);

        send(1, 3'd1, 1, 0, 64'h1000, 64'h40);
        step();
        chk("beq redirect", 64'(bus.redirect_valid), 1);
        chk("beq target", bus.redirect_target, 64'h1040);
        send(99, 3'd5, 0, 0, 64'h500, 64'h8);
        step();
        idle();
        chk("squash no output", 64'(bus.out_valid), 0);
        chk("squash no redirect", 64'(bus.redirect_valid), 0);

        send(2, 3'd2, 1, 0, 64'h2000, 64'h10);
        step();
        chk("bne not taken", 64'(bus.redirect_valid), 0);
        chk("bne out", bus.out_result, 2);
        send(3, 3'd5, 0, 0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20);
        step();
        idle();
        chk("jal redirect", 64'(bus.redirect_valid), 1);
        chk("jal wrap target", bus.redirect_target, 64'h10);
        step();
        chk("jal pulse one cycle", 64'(bus.redirect_valid), 0);

        bus.out_ready = 1'b0;
        send(40, 0, 0, 0, 0, 0);
        step();
        send(50, 0, 0, 0, 0, 0);
        step();
        chk("flush pre full", 64'(bus.in_ready), 0);
        bus.flush = 1'b1;
        send(60, 0, 0, 0, 0, 0);
        step();
        bus.flush = 1'b0;
        idle();
        chk("flush out_valid", 64'(bus.out_valid), 0);
        chk("flush in_ready", 64'(bus.in_ready), 1);
        step();
        chk("flush dropped", 64'(bus.out_valid), 0);

        send(55, 3'd5, 0, 0, 64'h2000, 64'h8);
        step();
        idle();
        chk("pre-reset valid", 64'(bus.out_valid), 1);
        chk("pre-reset redirect", 64'(bus.redirect_valid), 1);
        #2 reset = 1'b1;
        #1;
        chk("async out_valid", 64'(bus.out_valid), 0);
        chk("async redirect", 64'(bus.redirect_valid), 0);
        chk("async in_ready", 64'(bus.in_ready), 1);
        step();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        send(77, 0, 0, 0, 0, 0);
        step();
        idle();
        chk("post-reset out", bus.out_result, 77);
        chk("post-reset valid", 64'(bus.out_valid), 1);
        step();

        for (int i = 0; i < 8; i++) begin
            send(64'(100 + i), ops[i], i[0], i[1], 64'(i * 256), 64'(i * 3));
            bus.out_ready = (i % 3) != 1;
            step();
        end
        idle();
        bus.out_ready = 1'b1;
        step();
        step();
        step();
        chk("drained", 64'(bus.out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
